note_recorder: RTL and testbench
================================

# note_recorder

Recording companion to the automatic melody player: captures notes played live on the board's seven note keys and encodes each one into the player's 6-bit note code (pitch, octave and quantised duration). Codes go into an internal buffer that the player, or any other reader, fetches through a synchronous read port. It sits between the key/octave switches and the melody source selection of the music top level.

## Interface
- TICK_16, default 12_500_000: clock cycles in one sixteenth unit (0.125 s at 100 MHz).
- DEBOUNCE, default 1_000_000: cycles a raw key pattern must stay stable before it is accepted.
- DEPTH, default 64: buffer entries.
- ADDR_W, default 6: buffer address width, with 2^ADDR_W = DEPTH.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- rec_en  in  1  level; high = record
- key  in  7  raw note keys; bit0 = do … bit6 = si
- oct  in  2  00 middle, 01 low, 10 high; 11 treated as middle
- rd_addr  in  ADDR_W  buffer read address
- rd_data  out  6  registered buffer word
- length  out  ADDR_W+1  number of valid codes
- full  out  1  buffer reached DEPTH during the current take
- rec_busy  out  1  high while recording
- code_valid  out  1  one-cycle strobe per code written
- code_out  out  6  code written, valid with code_valid

## Operation
- Debounce: key_db takes a raw key value only after that value has been unchanged for DEBOUNCE consecutive cycles. If more than one bit is set, only the lowest set bit counts as the note.
- FSM states:
  - IDLE:
    - Leaves on a rec_en rising edge.
    - On that edge: length <= 0, full <= 0, rec_busy <= 1; go to SILENT.
    - No rests are logged before the first note of a take.
  - SILENT (recording, no note held):
    - When key_db becomes nonzero: latch pitch p (0..6) and oct, clear the duration counter, go to NOTE.
    - If at least one code exists in this take, count silence; every 2·TICK_16 cycles of continuous silence write code 0 (eighth rest).
  - NOTE:
    - Duration counter counts cycles, saturating at 4·TICK_16.
    - When key_db no longer equals the latched note, write the code.
    - Then: key_db zero → SILENT with the silence counter cleared; a different note → latch the new note and stay in NOTE.
- Duration quantisation, d = held cycles:
  - d < 2·TICK_16 → sixteenth
  - d < 4·TICK_16 → eighth
  - otherwise → quarter
- Code = base + p, with base by octave and duration:
  - middle: eighth 1, quarter 8, sixteenth 15
  - low: eighth 22, quarter 29, sixteenth 36
  - high: eighth 43, quarter 50, sixteenth 57
- Write: mem[length] <= code, length <= length+1, code_valid/code_out asserted.
- Full:
  - When a write makes length == DEPTH: full <= 1, rec_busy <= 0, go to IDLE.
  - Further key activity is ignored until the next rec_en rising edge.
- rec_en falls:
  - In NOTE: the held note is written immediately, with duration quantised from the count so far (unless full), then IDLE.
  - In SILENT: go to IDLE with no write.
  - rec_busy <= 0 on the same edge.
- Read: rd_data <= mem[rd_addr] every cycle, independent of recording state. Reads at addresses >= length return stale contents.

## Timing
- Reset values: rd_data 0, length 0, full 0, rec_busy 0, code_valid 0, code_out 0; FSM in IDLE; all counters 0. Buffer contents are not reset.
- Reset asserted mid-take: outputs return to reset values immediately and no partial code is written.
- Raw key edge to key_db change: DEBOUNCE+1 cycles.
- key_db change to write: the code_valid pulse and the length increment land on the next clock edge. A different-note switch writes the old code and latches the new note on that same edge.
- A silence-rest write and a note start falling on the same cycle: the note start wins and no rest is written.
- rd_addr to rd_data latency: 1 cycle.
- A rec_en rising edge while already busy has no effect.

## Test plan
Bench parameters: TICK_16 = 10, DEBOUNCE = 2, DEPTH = 4, ADDR_W = 2.

- Reset, then raise rec_en → rec_busy = 1, length = 0, code_valid stays low with no keys pressed.
- key = 0010000 (sol), oct = 00, held 25 cycles, then released → one code_valid with code_out = 5; length = 1; reading address 0 gives rd_data = 5 one cycle later.
- key = 0000001, oct = 01, held 50 cycles, then switched directly to key = 0100000, oct = 10, held 5 cycles, then released → codes 29 then 62 on consecutive writes.
- After one note, 45 cycles of silence → two code 0 writes, 20 cycles apart.
- Four notes recorded → full = 1, rec_busy = 0, length = 4; a fifth key press produces no code_valid.
- Key held, rec_en dropped after 15 cycles → one code 15 (middle do sixteenth), then IDLE.
- rst_n pulsed low mid-note → all outputs return to reset values asynchronously, with no write.

Source files
------------

// File: rtl/note_recorder_if.sv
// rtl/note_recorder_if.sv - read port and code stream bundle of the note recorder
// Purpose: groups the buffer read port and the recorder status/code outputs.
// Signals:
//   rd_addr    buffer read address (driven by the reader)
//   rd_data    registered buffer word, one cycle after rd_addr
//   length     number of valid codes in the current take
//   full       buffer filled during the current take
//   rec_busy   high while a take is being recorded
//   code_valid one-cycle strobe per code written
//   code_out   code written, valid with code_valid
interface note_recorder_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rd_addr;
  logic [5:0]        rd_data;
  logic [ADDR_W:0]   length;
  logic              full;
  logic              rec_busy;
  logic              code_valid;
  logic [5:0]        code_out;

  modport master (
    output rd_addr,
    input  rd_data, length, full, rec_busy, code_valid, code_out
  );

  modport slave (
    input  rd_addr,
    output rd_data, length, full, rec_busy, code_valid, code_out
  );
endinterface

// File: rtl/note_recorder.sv
// rtl/note_recorder.sv - live note capture and 6-bit melody code encoder
// Purpose: debounces the seven note keys, times each held note, encodes it as
// base(octave, duration) + pitch and appends it to an internal buffer; eighth
// rests are logged during silence once a take has at least one code.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   rec_en      level, high = record (a take starts on its rising edge)
//   key         raw note keys, bit0 = do .. bit6 = si
//   oct         00 middle, 01 low, 10 high, 11 middle
//   bus         read port and recorder status/code outputs (slave side)
module note_recorder #(
  parameter int TICK_16  = 12_500_000,
  parameter int DEBOUNCE = 1_000_000,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rec_en,
  input  logic [6:0]            key,
  input  logic [1:0]            oct,
  note_recorder_if.slave        bus
);

  localparam int DUR_W = $clog2(4 * TICK_16 + 1);
  localparam int SIL_W = $clog2(2 * TICK_16);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [DUR_W-1:0]  DUR_MAX   = DUR_W'(4 * TICK_16);
  // Thresholds on the counter value, which lags the held-cycle count by one.
  localparam logic [DUR_W-1:0]  DUR_8TH   = DUR_W'(2 * TICK_16 - 1);
  localparam logic [DUR_W-1:0]  DUR_4TH   = DUR_W'(4 * TICK_16 - 1);
  localparam logic [SIL_W-1:0]  SIL_LAST  = SIL_W'(2 * TICK_16 - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE);
  localparam logic [ADDR_W:0]   LEN_LAST  = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SILENT, NOTE} state_t;

  state_t             state_q, state_d;
  logic [6:0]         key_s_q, key_db_q;
  logic [DB_W-1:0]    db_cnt_q;
  logic               rec_en_q;
  logic [2:0]         p_q, p_d;
  logic [1:0]         o_q, o_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [SIL_W-1:0]   sil_q, sil_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic               full_q, full_d;
  logic               busy_q, busy_d;
  logic               code_valid_q;
  logic [5:0]         code_out_q;
  logic [5:0]         rd_data_q;
  logic [5:0]         mem [DEPTH];

  logic               note_on;
  logic [2:0]         note_p;
  logic [5:0]         held_code;
  logic [5:0]         oct_off, dur_off;
  logic               we;
  logic [5:0]         wcode;

  // A raw pattern is accepted once it has been sampled unchanged DEBOUNCE times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s_q  <= '0;
      key_db_q <= '0;
      db_cnt_q <= '0;
      rec_en_q <= 1'b0;
    end else begin
      rec_en_q <= rec_en;
      key_s_q  <= key;
      if (key != key_s_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q != DB_MAX) begin
        db_cnt_q <= db_cnt_q + 1'b1;
        if (db_cnt_q == DB_LAST) key_db_q <= key_s_q;
      end
    end
  end

  // Lowest set key wins when several are pressed.
  always_comb begin
    note_p = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (key_db_q[i]) note_p = 3'(i);
    end
  end
  assign note_on = |key_db_q;

  always_comb begin
    case (o_q)
      2'b01:   oct_off = 6'd21;
      2'b10:   oct_off = 6'd42;
      default: oct_off = 6'd0;
    endcase
    if (dur_q < DUR_8TH)      dur_off = 6'd15;
    else if (dur_q < DUR_4TH) dur_off = 6'd1;
    else                      dur_off = 6'd8;
    held_code = oct_off + dur_off + {3'b000, p_q};
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    o_d     = o_q;
    dur_d   = dur_q;
    sil_d   = sil_q;
    len_d   = len_q;
    full_d  = full_q;
    busy_d  = busy_q;
    we      = 1'b0;
    wcode   = held_code;
    case (state_q)
      IDLE: begin
        if (rec_en && !rec_en_q) begin
          len_d   = '0;
          full_d  = 1'b0;
          busy_d  = 1'b1;
          sil_d   = '0;
          state_d = SILENT;
        end
      end
      SILENT: begin
        if (!rec_en) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (note_on) begin
          p_d     = note_p;
          o_d     = oct;
          dur_d   = '0;
          state_d = NOTE;
        end else if (len_q != '0) begin
          if (sil_q == SIL_LAST) begin
            we    = 1'b1;
            wcode = 6'd0;
            sil_d = '0;
          end else begin
            sil_d = sil_q + 1'b1;
          end
        end
      end
      NOTE: begin
        if (dur_q != DUR_MAX) dur_d = dur_q + 1'b1;
        if (!rec_en) begin
          we      = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!note_on) begin
          we      = 1'b1;
          sil_d   = '0;
          state_d = SILENT;
        end else if (note_p != p_q) begin
          we    = 1'b1;
          p_d   = note_p;
          o_d   = oct;
          dur_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // The write that fills the buffer ends the take regardless of the branch above.
    if (we) begin
      len_d = len_q + 1'b1;
      if (len_q == LEN_LAST) begin
        full_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      p_q          <= '0;
      o_q          <= '0;
      dur_q        <= '0;
      sil_q        <= '0;
      len_q        <= '0;
      full_q       <= 1'b0;
      busy_q       <= 1'b0;
      code_valid_q <= 1'b0;
      code_out_q   <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      o_q          <= o_d;
      dur_q        <= dur_d;
      sil_q        <= sil_d;
      len_q        <= len_d;
      full_q       <= full_d;
      busy_q       <= busy_d;
      code_valid_q <= we;
      if (we) code_out_q <= wcode;
      rd_data_q    <= mem[bus.rd_addr];
    end
  end

  // Buffer storage has no reset; only IDLE never writes, so reset blocks writes.
  always_ff @(posedge clk) begin
    if (we) mem[len_q[ADDR_W-1:0]] <= wcode;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.length     = len_q;
  assign bus.full       = full_q;
  assign bus.rec_busy   = busy_q;
  assign bus.code_valid = code_valid_q;
  assign bus.code_out   = code_out_q;

endmodule

// File: tb/tb_note_recorder.sv
// tb/tb_note_recorder.sv - self-checking bench for note_recorder
module tb_note_recorder;
  localparam int TICK  = 10;
  localparam int DEB   = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rec_en = 1'b0;
  logic [6:0] key    = '0;
  logic [1:0] oct    = '0;

  note_recorder_if #(.ADDR_W(AW)) bus ();

  note_recorder #(
    .TICK_16(TICK), .DEBOUNCE(DEB), .DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .key(key), .oct(oct), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int got[$];
  int got_t[$];
  int expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.code_valid === 1'b1) begin
      got.push_back(int'(bus.code_out));
      got_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected code from the octave/duration base table plus pitch.
  function automatic int exp_code(input int p, input int o, input int d);
    int base [3][3] = '{'{15, 1, 8}, '{36, 22, 29}, '{57, 43, 50}};
    int oi = (o == 1) ? 1 : (o == 2) ? 2 : 0;
    int di = (d < 2 * TICK) ? 0 : (d < 4 * TICK) ? 1 : 2;
    return base[oi][di] + p;
  endfunction

  function automatic logic [6:0] pat(input int p, input logic [6:0] noise);
    logic [6:0] above = 7'h7f;
    logic [6:0] one   = 7'h01;
    above = above << (p + 1);
    one   = one << p;
    return one | (noise & above);
  endfunction

  task automatic start_take();
    got.delete();
    got_t.delete();
    expq.delete();
    rec_en = 1'b1;
    tick(2);
  endtask

  task automatic end_take();
    key = '0;
    tick(10);
    rec_en = 1'b0;
    tick(3);
  endtask

  task automatic check_take(input string tag);
    int n;
    n = (expq.size() > DEPTH) ? DEPTH : expq.size();
    check({tag, " count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      check($sformatf("%s code%0d", tag, i), got[i], expq[i]);
    check({tag, " length"}, bus.length, n);
    check({tag, " full"}, bus.full, (expq.size() >= DEPTH) ? 1 : 0);
    check({tag, " busy"}, bus.rec_busy, 0);
    for (int i = 0; i < n; i++) begin
      bus.rd_addr = AW'(i);
      tick(1);
      check($sformatf("%s mem%0d", tag, i), bus.rd_data, expq[i]);
    end
  endtask

  task automatic random_take(input int t);
    int nn, p, prev, o, h, g;
    bit direct;
    nn     = $urandom_range(1, 6);
    prev   = -1;
    direct = 1'b0;
    start_take();
    for (int i = 0; i < nn; i++) begin
      do p = $urandom_range(0, 6); while (direct && p == prev);
      o = $urandom_range(0, 3);
      h = $urandom_range(3, 50);
      key = pat(p, 7'($urandom));
      oct = 2'(o);
      tick(h);
      expq.push_back(exp_code(p, o, h));
      prev   = p;
      direct = ($urandom_range(0, 2) == 0) && (i != nn - 1);
      if (!direct && i != nn - 1) begin
        key = '0;
        g = $urandom_range(3, 50);
        tick(g);
        for (int r = 0; r < (g - 1) / (2 * TICK); r++) expq.push_back(0);
      end
    end
    end_take();
    check_take($sformatf("rnd%0d", t));
  endtask

  initial begin
    bus.rd_addr = '0;
    tick(2);
    check("rst length", bus.length, 0);
    check("rst busy", bus.rec_busy, 0);
    rst_n = 1'b1;
    tick(2);
    check("idle rd_data", bus.rd_data, 0);
    check("idle full", bus.full, 0);
    check("idle code_valid", bus.code_valid, 0);
    check("idle code_out", bus.code_out, 0);

    // Take 1: start, single note, direct switch.
    start_take();
    tick(10);
    check("t1 busy", bus.rec_busy, 1);
    check("t1 length0", bus.length, 0);
    check("t1 no code", got.size(), 0);
    key = 7'b0010000; oct = 2'b00; tick(25);
    key = '0; tick(5);
    check("t1 sol count", got.size(), 1);
    if (got.size() >= 1) check("t1 sol code", got[0], 5);
    check("t1 length1", bus.length, 1);
    bus.rd_addr = '0; tick(1);
    check("t1 read0", bus.rd_data, 5);
    key = 7'b0000001; oct = 2'b01; tick(50);
    key = 7'b0100000; oct = 2'b10; tick(5);
    end_take();
    expq = '{5, 29, 62};
    check_take("t1");

    // Take 2: rests after a note, then fill the buffer.
    start_take();
    key = 7'b0000001; oct = 2'b00; tick(10);
    key = '0; tick(45);
    key = 7'b0000010; oct = 2'b10; tick(30);
    key = '0; tick(6);
    expq = '{15, 0, 0, 44};
    if (got_t.size() >= 3) check("t2 rest spacing", got_t[2] - got_t[1], 2 * TICK);
    else check("t2 rest present", got_t.size(), 3);
    key = 7'b1000000; tick(10);
    key = '0; tick(10);
    check("t2 no 5th", got.size(), 4);
    rec_en = 1'b0; tick(3);
    check_take("t2");

    // Take 3: rec_en dropped with a note held.
    start_take();
    key = 7'b0000001; oct = 2'b00; tick(15);
    rec_en = 1'b0; tick(3);
    key = '0; tick(5);
    expq = '{15};
    check_take("t3");

    // Take 4: asynchronous reset in the middle of a note.
    start_take();
    key = 7'b0001000; oct = 2'b01; tick(10);
    #2 rst_n = 1'b0;
    #1;
    check("t4 rst length", bus.length, 0);
    check("t4 rst busy", bus.rec_busy, 0);
    check("t4 rst full", bus.full, 0);
    check("t4 rst code_out", bus.code_out, 0);
    check("t4 rst rd_data", bus.rd_data, 0);
    rec_en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    key = '0;
    tick(10);
    check("t4 no write", got.size(), 0);
    check("t4 code_valid", bus.code_valid, 0);

    for (int t = 0; t < 30; t++) random_take(t);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
